uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, 8N1 format, LSB first. It is the receive-side counterpart of uart_tx and uses the same FREQ/RATE parameterisation. It samples the asynchronous RXD pin and emits one-cycle valid-strobed bytes into the clk domain. It also flags framing errors. It sits at the FPGA top level, directly on the RXD pad, and feeds loopback or command logic.

Parameters:
FREQ, 50_000_000, clk frequency in Hz
RATE, 2_000_000, baud rate in bit/s

Ports:
clk  input  1  system clock; the only clock
rst  input  1  synchronous reset, active-high
i_rx  input  1  raw serial line; asynchronous; idles high
o_data  output  8  last received byte; held stable between frames
o_vld  output  1  one-cycle strobe; o_data is valid in the same cycle
o_err  output  1  one-cycle strobe on framing error (stop bit sampled low)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. All flops update on posedge clk. rst is sampled only on the clock edge.
- Derived constants:
  - DIV = (FREQ + RATE/2) / RATE, rounded. Defaults give DIV = 25.
  - HALF = DIV/2, integer division. Defaults give HALF = 12.
  - Bit counter width = $clog2(DIV).
  - DIV < 4 is illegal; the block must fail elaboration.
- Input synchroniser:
  - Two flops, rx_s1 then rx_s. Both reset to 1.
  - The FSM sees only rx_s, which is i_rx delayed by 2 cycles.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE:
    - cnt = 0, bit_idx = 0.
    - If rx_s == 0, go to START with cnt = 0.
  - START:
    - cnt increments each cycle.
    - At cnt == HALF-1, sample rx_s (mid start bit).
    - If rx_s == 1: glitch; return to IDLE with no output.
    - If rx_s == 0: go to DATA with cnt = 0, bit_idx = 0.
  - DATA:
    - cnt increments each cycle.
    - At cnt == DIV-1: shift rx_s into shreg[7] and shift right (LSB first), set cnt = 0, bit_idx++.
    - After the 8th sample (bit_idx == 7 at the sample), go to STOP.
  - STOP:
    - At cnt == DIV-1, sample rx_s.
    - If rx_s == 1: o_data <= shreg, pulse o_vld for 1 cycle, go to IDLE.
    - If rx_s == 0: pulse o_err for 1 cycle, leave o_data unchanged, go to BREAK.
  - BREAK:
    - Wait until rx_s == 1, then go to IDLE.
    - This prevents a held-low line from re-triggering frames.
- Sample points: each data and stop sample lands about mid-bit. The 1st data sample is at HALF + DIV cycles after start detection.
- Latency: o_vld asserts exactly 2 + 1 + HALF + 9*DIV cycles after the first clk edge at which i_rx is sampled low. Defaults give 240 cycles.
- Back-to-back frames: a new start bit may begin in the cycle after STOP returns to IDLE. There is no dead time beyond that; a stop bit of length 1.0 must be sufficient.
- o_vld and o_err are never high in the same cycle.
- Neither o_vld nor o_err is asserted more than once per frame.
- Reset values: o_data = 8'h00, o_vld = 0, o_err = 0, state = IDLE, cnt = 0, bit_idx = 0, shreg = 0, synchroniser = 1.
- Reset mid-frame: the partial frame is discarded and no strobe is generated. After rst drops, a frame needs a fresh falling edge. If the line is still low, it is treated as a start bit.
- Baud tolerance: correct reception for transmitter baud error of at least ±3% at default parameters.
- No flow control. The consumer must take o_data on o_vld. o_data is overwritten only by the next good frame.

Test Plan:
- Single byte 8'h35 at RATE, ideal timing -> exactly one o_vld, o_data = 8'h35, o_vld 240 cycles after i_rx falls, o_err stays 0.
- Back-to-back 8'h00, 8'hFF, 8'hA5, 8'h5A with 1-bit stop -> four o_vld pulses with matching data in order, no o_err.
- Start glitch: i_rx low for 8 cycles (< HALF), then high -> no o_vld, no o_err, FSM back in IDLE; a following 8'h3C is received correctly.
- Framing error: 8'h81 with stop bit driven low, then line held low 100 cycles before going high -> one o_err pulse, no o_vld, o_data unchanged; a subsequent 8'h42 yields o_vld with 8'h42.
- Reset mid-frame: assert rst for 1 cycle during data bit 4 of 8'hC3 -> no strobe for that frame, outputs at reset values; a next clean frame 8'h17 is received correctly.
- Baud skew plus loopback: connect uart_tx (same FREQ) with its RATE scaled ±3%, send a 0x30..0x3F ramp -> all 16 bytes received correctly, no o_err.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first. It double-flops the asynchronous RXD pin and
// emits each received byte with a one-cycle valid strobe. A stop bit sampled
// low produces a one-cycle framing-error strobe instead.
module uart_rx #(
   parameter int unsigned FREQ = 50_000_000,
   parameter int unsigned RATE = 2_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_vld,
   output logic       o_err
);

   localparam int unsigned DIV  = (FREQ + RATE / 2) / RATE;
   localparam int unsigned HALF = DIV / 2;
   localparam int unsigned CW   = $clog2(DIV);

   localparam logic [CW-1:0] CntHalfLast = CW'(HALF - 1);
   localparam logic [CW-1:0] CntBitLast  = CW'(DIV - 1);

   // With fewer than four clocks per bit there is no usable mid-bit sample point.
   if (DIV < 4) begin : g_div_check
      $error("uart_rx: FREQ/RATE gives DIV < 4");
   end

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } state_e;

   state_e        state_q, state_d;
   logic          rx_s1_q, rx_s_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [7:0]    data_q, data_d;
   logic          vld_q, vld_d;
   logic          err_q, err_d;

   // State, synchroniser and output registers; synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1_q   <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= StIdle;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         data_q    <= '0;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         rx_s1_q   <= i_rx;
         rx_s_q    <= rx_s1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         data_q    <= data_d;
         vld_q     <= vld_d;
         err_q     <= err_d;
      end
   end

   // Next-state logic: bit timing, sampling, and strobe generation.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      data_d    = data_q;
      vld_d     = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            cnt_d     = '0;
            bit_idx_d = '0;
            if (!rx_s_q) begin
               state_d = StStart;
            end
         end
         StStart: begin
            cnt_d = cnt_q + CW'(1);
            // Mid start bit: a high line here was only a glitch.
            if (cnt_q == CntHalfLast) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rx_s_q ? StIdle : StData;
            end
         end
         StData: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CntBitLast) begin
               cnt_d     = '0;
               shreg_d   = {rx_s_q, shreg_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end
            end
         end
         StStop: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CntBitLast) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  data_d  = shreg_q;
                  vld_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  err_d   = 1'b1;
                  state_d = StBreak;
               end
            end
         end
         StBreak: begin
            // Hold off until the line returns high so a stuck-low line cannot re-trigger.
            cnt_d = '0;
            if (rx_s_q) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign o_data = data_q;
   assign o_vld  = vld_q;
   assign o_err  = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (DIV = 25, HALF = 12).
module tb_uart_rx;

   localparam int unsigned DIV = 25;

   logic       clk;
   logic       rst;
   logic       i_rx;
   logic [7:0] o_data;
   logic       o_vld;
   logic       o_err;

   int checks = 0;
   int errors = 0;

   int          cyc = 0;
   int          vld_cnt = 0;
   int          err_cnt = 0;
   int          both_cnt = 0;
   int          last_vld_cyc = 0;
   logic [7:0]  rxq[$];

   uart_rx #(
      .FREQ(50_000_000),
      .RATE(2_000_000)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .i_rx  (i_rx),
      .o_data(o_data),
      .o_vld (o_vld),
      .o_err (o_err)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe strobes away from the active edge.
   always @(negedge clk) begin
      if (o_vld) begin
         vld_cnt++;
         last_vld_cyc = cyc;
         rxq.push_back(o_data);
      end
      if (o_err) err_cnt++;
      if (o_vld && o_err) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_byte(input string tag, input logic [7:0] exp);
      logic [31:0] got;
      if (rxq.size() == 0) got = 32'hFFFF_FFFF;
      else got = {24'h0, rxq.pop_front()};
      check(tag, got, {24'h0, exp});
   endtask

   task automatic idle(input int n);
      i_rx = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Cycle-exact frame; abort_at >= 0 pulses rst at that frame cycle and idles the line.
   task automatic send_frame(input logic [7:0] d, input logic stop, input int abort_at,
                             output int fall_cyc);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      fall_cyc = cyc;
      for (int c = 0; c < 10 * DIV; c++) begin
         i_rx = f[c / DIV];
         if (c == abort_at) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst  = 1'b0;
            i_rx = 1'b1;
            return;
         end
         @(posedge clk);
         #1;
      end
   endtask

   // Free-running transmitter with an arbitrary bit period in time units.
   task automatic send_timed(input logic [7:0] d, input real bit_t);
      logic [9:0] f;
      f = {1'b1, d, 1'b0};
      for (int b = 0; b < 10; b++) begin
         i_rx = f[b];
         #(bit_t);
      end
   endtask

   initial begin
      int fall;
      int v0, e0;
      logic [7:0] bytes4 [4];
      bytes4[0] = 8'h00;
      bytes4[1] = 8'hFF;
      bytes4[2] = 8'hA5;
      bytes4[3] = 8'h5A;

      rst  = 1'b1;
      i_rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_data", {24'h0, o_data}, 32'h00);
      check("reset_vld", {31'h0, o_vld}, 32'h0);
      check("reset_err", {31'h0, o_err}, 32'h0);
      idle(5);

      // Single byte with latency measurement.
      send_frame(8'h35, 1'b1, -1, fall);
      idle(20);
      check("single_vld_cnt", vld_cnt, 1);
      expect_byte("single_data", 8'h35);
      check("single_latency", last_vld_cyc - fall, 240);
      check("single_err", err_cnt, 0);

      // Back-to-back frames with no gap after the stop bit.
      v0 = vld_cnt;
      for (int i = 0; i < 4; i++) send_frame(bytes4[i], 1'b1, -1, fall);
      idle(20);
      check("b2b_vld_cnt", vld_cnt - v0, 4);
      expect_byte("b2b_0", 8'h00);
      expect_byte("b2b_1", 8'hFF);
      expect_byte("b2b_2", 8'hA5);
      expect_byte("b2b_3", 8'h5A);
      check("b2b_err", err_cnt, 0);

      // Start glitch shorter than half a bit.
      v0 = vld_cnt;
      i_rx = 1'b0;
      repeat (8) begin
         @(posedge clk);
         #1;
      end
      idle(60);
      check("glitch_vld", vld_cnt - v0, 0);
      check("glitch_err", err_cnt, 0);
      check("glitch_idle", {29'h0, dut.state_q}, 32'h0);
      send_frame(8'h3C, 1'b1, -1, fall);
      idle(10);
      expect_byte("glitch_next", 8'h3C);

      // Framing error followed by a held-low line.
      v0 = vld_cnt;
      e0 = err_cnt;
      send_frame(8'h81, 1'b0, -1, fall);
      i_rx = 1'b0;
      repeat (100) begin
         @(posedge clk);
         #1;
      end
      idle(30);
      check("frame_err_cnt", err_cnt - e0, 1);
      check("frame_vld", vld_cnt - v0, 0);
      check("frame_data_held", {24'h0, o_data}, 32'h3C);
      send_frame(8'h42, 1'b1, -1, fall);
      idle(10);
      expect_byte("frame_next", 8'h42);

      // Reset in the middle of data bit 4 of 0xC3; the sender abandons the frame too.
      v0 = vld_cnt;
      e0 = err_cnt;
      send_frame(8'hC3, 1'b1, 5 * DIV + 12, fall);
      check("rst_data", {24'h0, o_data}, 32'h00);
      idle(300);
      check("rst_vld", vld_cnt - v0, 0);
      check("rst_err", err_cnt - e0, 0);
      check("rst_data_after", {24'h0, o_data}, 32'h00);
      send_frame(8'h17, 1'b1, -1, fall);
      idle(10);
      expect_byte("rst_next", 8'h17);

      // Baud skew: transmitter 3% fast, then 3% slow; nominal bit is 500 time units.
      e0 = err_cnt;
      for (int i = 0; i < 16; i++) send_timed(8'(8'h30 + i), 500.0 / 1.03);
      idle(40);
      for (int i = 0; i < 16; i++) expect_byte("skew_fast", 8'(8'h30 + i));
      for (int i = 0; i < 16; i++) send_timed(8'(8'h30 + i), 500.0 / 0.97);
      idle(40);
      for (int i = 0; i < 16; i++) expect_byte("skew_slow", 8'(8'h30 + i));
      check("skew_err", err_cnt - e0, 0);

      check("never_both", both_cnt, 0);
      check("no_extra_bytes", rxq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
